// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator and decoder: FSM states,
// Gray-coded phase values {B,A} and the phase-advance rule.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // Up order is PH0->PH1->PH2->PH3->PH0; dir=1 walks it backwards.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
    logic [1:0] nxt;
    case (phase)
      PH0:     nxt = dir ? PH3 : PH1;
      PH1:     nxt = dir ? PH0 : PH2;
      PH2:     nxt = dir ? PH1 : PH3;
      default: nxt = dir ? PH2 : PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_tick_div.sv
// Reloadable down-counter: tick is high while enabled with the count at zero.
module quad_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             f_clk_1,
  input  logic             nreset,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  input  logic             enable,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge f_clk_1 or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - DIV_W'(1);
    end
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder signal generator: emits bursts or a continuous stream of
// Gray-coded A/B steps at a programmable rate and tracks a signed position.
module quad_gen
  import quad_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int POS_W = 32
) (
  input  logic             f_clk_1,
  input  logic             nreset,
  input  logic             start,
  input  logic             dir,
  input  logic             cont,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] half_period,
  input  logic             abort,
  output logic             quad_a,
  output logic             quad_b,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] position
);

  state_t           state, state_nxt;
  logic             dir_q, cont_q;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] h_m1;
  logic [1:0]       phase;

  logic             done_nxt, accept, step;
  logic             div_load, div_tick, div_enable;
  logic [DIV_W-1:0] div_value, h_start;

  // A half_period of 0 behaves as 1, so the reload value H-1 bottoms out at 0.
  assign h_start    = (half_period == '0) ? '0 : half_period - DIV_W'(1);
  assign div_enable = (state == RUN) && !abort;

  quad_tick_div #(.DIV_W(DIV_W)) u_div (
    .f_clk_1 (f_clk_1),
    .nreset  (nreset),
    .load    (div_load),
    .value   (div_value),
    .enable  (div_enable),
    .tick    (div_tick)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_nxt = state;
    done_nxt  = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    div_load  = 1'b0;
    div_value = h_m1;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if ((steps != '0) || cont) begin
              accept    = 1'b1;
              state_nxt = RUN;
              div_load  = 1'b1;
              div_value = h_start;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (div_tick) begin
            step     = 1'b1;
            div_load = 1'b1;
            if (!cont_q && (remaining == CNT_W'(1))) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge f_clk_1 or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      done      <= 1'b0;
      dir_q     <= 1'b0;
      cont_q    <= 1'b0;
      remaining <= '0;
      h_m1      <= '0;
      phase     <= PH0;
      position  <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (accept) begin
        dir_q     <= dir;
        cont_q    <= cont;
        remaining <= steps;
        h_m1      <= h_start;
      end
      if (step) begin
        phase    <= next_phase(phase, dir_q);
        position <= dir_q ? position - POS_W'(1) : position + POS_W'(1);
        if (!cont_q) begin
          remaining <= remaining - CNT_W'(1);
        end
      end
    end
  end

  assign quad_a = phase[0];
  assign quad_b = phase[1];
  assign busy   = (state == RUN);

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: directed scenarios plus randomized bursts
// and aborts, compared against an arithmetic step-count model.
module tb_quad_gen;

  localparam int DIV_W = 16;
  localparam int CNT_W = 16;
  localparam int POS_W = 8;

  logic             f_clk_1 = 1'b0;
  logic             nreset  = 1'b0;
  logic             start   = 1'b0;
  logic             dir     = 1'b0;
  logic             cont    = 1'b0;
  logic             abort   = 1'b0;
  logic [CNT_W-1:0] steps   = '0;
  logic [DIV_W-1:0] half_period = '0;
  logic             quad_a, quad_b, busy, done;
  logic [POS_W-1:0] position;

  quad_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .f_clk_1     (f_clk_1),
    .nreset      (nreset),
    .start       (start),
    .dir         (dir),
    .cont        (cont),
    .steps       (steps),
    .half_period (half_period),
    .abort       (abort),
    .quad_a      (quad_a),
    .quad_b      (quad_b),
    .busy        (busy),
    .done        (done),
    .position    (position)
  );

  always #5 f_clk_1 = ~f_clk_1;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase index into the up-order Gray table, and signed position.
  int m_idx = 0;
  int m_pos = 0;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ab_at(input int idx);
    return gray[((idx % 4) + 4) % 4];
  endfunction

  task automatic check_state(input string tag, input int idx, input int pos,
                             input bit exp_busy, input bit exp_done);
    check({tag, " ab"},   {30'b0, quad_b, quad_a}, {30'b0, ab_at(idx)});
    check({tag, " pos"},  {24'b0, position}, pos & 32'hFF);
    check({tag, " busy"}, {31'b0, busy}, {31'b0, exp_busy});
    check({tag, " done"}, {31'b0, done}, {31'b0, exp_done});
  endtask

  task automatic tick();
    @(posedge f_clk_1);
    #1;
  endtask

  // Step n of S lands after edge k+n*H; busy drops and done pulses after k+S*H.
  task automatic run_burst(input int s, input int hp, input bit d, input string tag);
    int h, sg, n;
    h  = (hp == 0) ? 1 : hp;
    sg = d ? -1 : 1;
    steps = CNT_W'(s); half_period = DIV_W'(hp); dir = d; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    steps = CNT_W'($urandom); half_period = DIV_W'($urandom);
    dir = 1'($urandom); cont = 1'($urandom);
    if (s == 0) begin
      check_state(tag, m_idx, m_pos, 1'b0, 1'b1);
    end else begin
      for (int t = 0; t <= s * h; t++) begin
        if (t > 0) tick();
        n = t / h;
        check_state(tag, m_idx + sg * n, m_pos + sg * n, t < s * h, t == s * h);
      end
    end
    m_idx += sg * s;
    m_pos += sg * s;
    cont = 1'b0;
    tick();
    check_state({tag, " after"}, m_idx, m_pos, 1'b0, 1'b0);
  endtask

  // Continuous run aborted when edge k+a samples abort; steps before it count.
  task automatic run_abort(input int hp, input int a, input bit d, input bit poke, input string tag);
    int h, sg, n;
    h  = (hp == 0) ? 1 : hp;
    sg = d ? -1 : 1;
    steps = CNT_W'($urandom); half_period = DIV_W'(hp); dir = d; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    half_period = DIV_W'($urandom); dir = 1'($urandom); cont = 1'($urandom);
    for (int t = 0; t <= a; t++) begin
      if (t > 0) tick();
      n = (t < a) ? t / h : (a - 1) / h;
      check_state(tag, m_idx + sg * n, m_pos + sg * n, t < a, 1'b0);
      if (t < a) begin
        if (poke && t == 3) begin
          start = 1'b1; steps = CNT_W'($urandom_range(1, 9));
        end
        if (t == 4) start = 1'b0;
        if (t == a - 1) abort = 1'b1;
      end
    end
    abort = 1'b0;
    cont  = 1'b0;
    m_idx += sg * ((a - 1) / h);
    m_pos += sg * ((a - 1) / h);
    repeat (3) begin
      tick();
      check_state({tag, " held"}, m_idx, m_pos, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int need;
    #12;
    check_state("reset", 0, 0, 1'b0, 1'b0);
    nreset = 1'b1;
    tick();

    // Reset in the middle of a burst clears outputs without waiting for a clock.
    steps = 4; half_period = 3; dir = 1'b0; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid pos", {24'b0, position}, 32'd1);
    #2 nreset = 1'b0;
    #1;
    m_idx = 0; m_pos = 0;
    check_state("async rst", 0, 0, 1'b0, 1'b0);
    tick();
    #2 nreset = 1'b1;
    tick();

    run_burst(8, 3, 1'b0, "up8");
    run_burst(5, 0, 1'b1, "dn5 h0");
    run_abort(2, 7, 1'b0, 1'b1, "abort");
    run_burst(0, 2, 1'b0, "zero");

    // start together with abort in IDLE: abort wins.
    steps = 3; half_period = 1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_state("start+abort", m_idx, m_pos, 1'b0, 1'b0);
    tick();
    check_state("start+abort 2", m_idx, m_pos, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(1, 10);
        run_abort($urandom_range(0, 3), a, 1'($urandom), a >= 6, "rnd abort");
      end else begin
        run_burst($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom), "rnd burst");
      end
    end

    // Position wrap at POS_W=8: 127 -> -128 -> -127 and back.
    need = ((127 - m_pos) % 256 + 256) % 256;
    if (need != 0) run_burst(need, 0, 1'b0, "to127");
    check("at 127", {24'b0, position}, 32'h7F);
    run_burst(2, 1, 1'b0, "wrap up");
    check("wrapped", {24'b0, position}, 32'h81);
    run_burst(2, 0, 1'b1, "wrap dn");
    check("back 127", {24'b0, position}, 32'h7F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
